gtxe2_chnl_cpll_lockdet: RTL and testbench

//  Lock/loss detector for the channel CPLL model, directly downstream of the CPLL clock generator.

---
 rtl/gtxe2_chnl_cpll_lockdet.sv | 194 +++++++++++++++++++
 tb/tb_gtxe2_chnl_cpll_lockdet.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// CPLL lock / clock-loss detector: counts synchronised ref/fb toggle events per window on CPLLLOCKDETCLK.
// Optional build macro GTXE2_CHNL_CPLL_LOCKDET_STICKY_EN makes the two lost flags sticky until reset or disable.
module gtxe2_chnl_cpll_lockdet #(
    parameter int WINDOW       = 256,
    parameter int REF_MIN      = 8,
    parameter int FB_EXPECT    = 32,
    parameter int FB_TOL       = 2,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic CPLLLOCKDETCLK,
    input  logic reset,
    input  logic CPLLLOCKEN,
    input  logic ref_tgl,
    input  logic fb_tgl,
    output logic CPLLLOCK,
    output logic CPLLREFCLKLOST,
    output logic CPLLFBCLKLOST,
    output logic pll_locked
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int GC_W  = $clog2(LOCK_WINDOWS + 1);

    localparam int FB_LO_INT = (FB_EXPECT > FB_TOL) ? (FB_EXPECT - FB_TOL) : 0;
    localparam int FB_HI_INT = FB_EXPECT + FB_TOL;
    localparam logic signed [16:0] FB_LO = 17'(FB_LO_INT);
    localparam logic signed [16:0] FB_HI = 17'(FB_HI_INT);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [GC_W-1:0]  GC_LOCK  = GC_W'(LOCK_WINDOWS);
    localparam logic [15:0]      REF_MIN_V = 16'(REF_MIN);

`ifdef GTXE2_CHNL_CPLL_LOCKDET_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COUNT  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Saturating event counter increment: holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic inc);
        logic [15:0] res;
        if (inc && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic             ref_meta_r, ref_sync_r, ref_prev_r;
    logic             fb_meta_r, fb_sync_r, fb_prev_r;
    logic [1:0]       state_r;
    logic [WIN_W-1:0] win_cnt_r;
    logic [15:0]      ref_cnt_r, fb_cnt_r;
    logic [GC_W-1:0]  good_cnt_r;
    logic             lock_r, ref_lost_r, fb_lost_r;

    logic             ref_evt_s, fb_evt_s, win_term_s;
    logic [15:0]      ref_total_s, fb_total_s;
    logic signed [16:0] fb_signed_s;
    logic             ref_bad_s, fb_bad_s, fb_zero_s, win_good_s;
    logic [GC_W-1:0]  good_inc_s;

    logic [1:0]       state_nxt_s;
    logic [WIN_W-1:0] win_cnt_nxt_s;
    logic [15:0]      ref_cnt_nxt_s, fb_cnt_nxt_s;
    logic [GC_W-1:0]  good_nxt_s;
    logic             lock_nxt_s, ref_lost_nxt_s, fb_lost_nxt_s;

    // Two-flop synchronisers plus one delay stage for edge detection of both toggles.
    always_ff @(posedge CPLLLOCKDETCLK or posedge reset) begin
        if (reset) begin
            ref_meta_r <= 1'b0;
            ref_sync_r <= 1'b0;
            ref_prev_r <= 1'b0;
            fb_meta_r  <= 1'b0;
            fb_sync_r  <= 1'b0;
            fb_prev_r  <= 1'b0;
        end else begin
            ref_meta_r <= ref_tgl;
            ref_sync_r <= ref_meta_r;
            ref_prev_r <= ref_sync_r;
            fb_meta_r  <= fb_tgl;
            fb_sync_r  <= fb_meta_r;
            fb_prev_r  <= fb_sync_r;
        end
    end

    assign ref_evt_s   = ref_sync_r ^ ref_prev_r;
    assign fb_evt_s    = fb_sync_r ^ fb_prev_r;
    assign win_term_s  = (win_cnt_r == WIN_LAST);

    // Totals include an event landing on the terminal cycle itself.
    assign ref_total_s = sat_inc(ref_cnt_r, ref_evt_s);
    assign fb_total_s  = sat_inc(fb_cnt_r, fb_evt_s);
    assign fb_signed_s = {1'b0, fb_total_s};

    assign ref_bad_s   = (ref_total_s < REF_MIN_V);
    assign fb_bad_s    = (fb_signed_s < FB_LO) || (fb_signed_s > FB_HI);
    assign fb_zero_s   = !ref_bad_s && (fb_total_s == 16'h0000);
    assign win_good_s  = !ref_bad_s && !fb_bad_s;
    assign good_inc_s  = good_cnt_r + GC_W'(1);

    // Next-state logic: window bookkeeping, evaluation at the terminal cycle, lock FSM.
    always_comb begin
        state_nxt_s    = ST_IDLE;
        win_cnt_nxt_s  = '0;
        ref_cnt_nxt_s  = 16'h0000;
        fb_cnt_nxt_s   = 16'h0000;
        good_nxt_s     = '0;
        lock_nxt_s     = 1'b0;
        ref_lost_nxt_s = 1'b0;
        fb_lost_nxt_s  = 1'b0;
        if (!CPLLLOCKEN) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_COUNT;
                end
                ST_COUNT, ST_LOCKED: begin
                    state_nxt_s    = state_r;
                    good_nxt_s     = good_cnt_r;
                    lock_nxt_s     = lock_r;
                    ref_lost_nxt_s = ref_lost_r;
                    fb_lost_nxt_s  = fb_lost_r;
                    if (win_term_s) begin
                        ref_lost_nxt_s = ref_bad_s | (STICKY & ref_lost_r);
                        fb_lost_nxt_s  = fb_zero_s | (STICKY & fb_lost_r);
                        if (state_r == ST_LOCKED) begin
                            if (!win_good_s) begin
                                state_nxt_s = ST_COUNT;
                                good_nxt_s  = '0;
                                lock_nxt_s  = 1'b0;
                            end else begin
                                lock_nxt_s  = 1'b1;
                            end
                        end else if (win_good_s) begin
                            if (good_inc_s == GC_LOCK) begin
                                state_nxt_s = ST_LOCKED;
                                good_nxt_s  = '0;
                                lock_nxt_s  = 1'b1;
                            end else begin
                                good_nxt_s  = good_inc_s;
                            end
                        end else begin
                            good_nxt_s = '0;
                        end
                    end else begin
                        win_cnt_nxt_s = win_cnt_r + WIN_W'(1);
                        ref_cnt_nxt_s = ref_total_s;
                        fb_cnt_nxt_s  = fb_total_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CPLLLOCKDETCLK or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            win_cnt_r  <= '0;
            ref_cnt_r  <= 16'h0000;
            fb_cnt_r   <= 16'h0000;
            good_cnt_r <= '0;
            lock_r     <= 1'b0;
            ref_lost_r <= 1'b0;
            fb_lost_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            win_cnt_r  <= win_cnt_nxt_s;
            ref_cnt_r  <= ref_cnt_nxt_s;
            fb_cnt_r   <= fb_cnt_nxt_s;
            good_cnt_r <= good_nxt_s;
            lock_r     <= lock_nxt_s;
            ref_lost_r <= ref_lost_nxt_s;
            fb_lost_r  <= fb_lost_nxt_s;
        end
    end

    assign CPLLLOCK       = lock_r;
    assign pll_locked     = lock_r;
    assign CPLLREFCLKLOST = ref_lost_r;
    assign CPLLFBCLKLOST  = fb_lost_r;

endmodule

// File: tb/tb_gtxe2_chnl_cpll_lockdet.sv
// Scoreboard bench for gtxe2_chnl_cpll_lockdet: per-window event counts drive a window-level reference model.
module tb_gtxe2_chnl_cpll_lockdet;

    logic clk = 1'b0;
    logic reset, en, ref_tgl, fb_tgl;
    logic lock, refl, fbl, pll_locked;

    gtxe2_chnl_cpll_lockdet dut (
        .CPLLLOCKDETCLK (clk),
        .reset          (reset),
        .CPLLLOCKEN     (en),
        .ref_tgl        (ref_tgl),
        .fb_tgl         (fb_tgl),
        .CPLLLOCK       (lock),
        .CPLLREFCLKLOST (refl),
        .CPLLFBCLKLOST  (fbl),
        .pll_locked     (pll_locked)
    );

    always #5 clk = ~clk;

`ifdef GTXE2_CHNL_CPLL_LOCKDET_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    typedef struct {
        int   at;
        logic lk;
        logic rl;
        logic fl;
        int   id;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   win_id = 0;

    // window-level reference state
    int   m_gc = 0;
    bit   m_lk = 1'b0;
    bit   m_rl = 1'b0;
    bit   m_fl = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int at);
        sb.push_back('{at, m_lk, m_rl, m_fl, win_id});
    endtask

    task automatic model_clear();
        m_gc = 0; m_lk = 1'b0; m_rl = 1'b0; m_fl = 1'b0;
    endtask

    task automatic model_window(input int r, input int f);
        bit rb, fbb, good, fz;
        rb   = (r < 8);
        fbb  = (f < 30) || (f > 34);
        good = !rb && !fbb;
        fz   = !rb && (f == 0);
        if (m_lk) begin
            if (!good) begin m_lk = 1'b0; m_gc = 0; end
        end else if (good) begin
            m_gc++;
            if (m_gc == 4) begin m_lk = 1'b1; m_gc = 0; end
        end else begin
            m_gc = 0;
        end
        m_rl = STK ? (m_rl | rb) : rb;
        m_fl = STK ? (m_fl | fz) : fz;
    endtask

    // Called at the negedge of window cycle 0; returns at the negedge of cycle 'stop'.
    task automatic run_window(input int r, input int f, input int stop);
        int rs, fs;
        rs = $urandom_range(4, 40);
        fs = $urandom_range(4, 40);
        for (int i = 0; i < stop; i++) begin
            if (r > 0 && i >= rs && i < rs + 3 * r && ((i - rs) % 3) == 0) ref_tgl = ~ref_tgl;
            if (f > 0 && i >= fs && i < fs + 3 * f && ((i - fs) % 3) == 0) fb_tgl = ~fb_tgl;
            if (i == 250) begin
                push_exp(cyc + 5);
                model_window(r, f);
                push_exp(cyc + 6);
            end
            @(negedge clk);
        end
        win_id++;
    endtask

    task automatic good_windows(input int n);
        for (int k = 0; k < n; k++) run_window(16, 32, 256);
    endtask

    // Monitor: compare every due expectation against the registered outputs.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.at != cyc || lock !== e.lk || pll_locked !== e.lk || refl !== e.rl || fbl !== e.fl) begin
                errors++;
                $display("FAIL win_check id=%0d cyc=%0d due=%0d got lock=%0b pll=%0b refl=%0b fbl=%0b want lock=%0b refl=%0b fbl=%0b",
                         e.id, cyc, e.at, lock, pll_locked, refl, fbl, e.lk, e.rl, e.fl);
            end
        end
    end

    initial begin
        int r, f, sel;
        reset = 1'b1; en = 1'b0; ref_tgl = 1'b0; fb_tgl = 1'b0;
        repeat (3) @(negedge clk);
        push_exp(cyc + 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(cyc + 1);
        en = 1'b1;
        @(negedge clk);

        // nominal lock, then ref loss and the REF_MIN boundary
        good_windows(4);
        good_windows(1);
        run_window(0, 32, 256);
        run_window(7, 32, 256);
        run_window(8, 32, 256);

        // fb loss and tolerance edges
        run_window(16, 0, 256);
        for (int k = 0; k < 4; k++) run_window(16, 30, 256);
        run_window(16, 34, 256);
        run_window(16, 35, 256);
        for (int k = 0; k < 3; k++) run_window(16, 34, 256);
        run_window(16, 29, 256);
        for (int k = 0; k < 4; k++) run_window(16, (k % 2 == 0) ? 30 : 34, 256);

        // enable dropped at window cycle 100 while locked, then relock
        run_window(16, 32, 100);
        en = 1'b0;
        model_clear();
        push_exp(cyc + 1);
        @(negedge clk);
        push_exp(cyc + 1);
        en = 1'b1;
        @(negedge clk);
        good_windows(4);

        // async reset pulse mid-window while locked, then relock
        run_window(16, 32, 100);
        model_clear();
        push_exp(cyc + 1);
        #2 reset = 1'b1;
        ref_tgl = 1'b0;
        fb_tgl = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        good_windows(4);

        // one window without ref clock, then recovery (sticky build keeps the flag)
        run_window(0, 32, 256);
        good_windows(5);

        // randomised windows
        for (int k = 0; k < 14; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                r = $urandom_range(8, 16);
                f = $urandom_range(30, 34);
            end else if (sel < 8) begin
                r = $urandom_range(0, 16);
                f = $urandom_range(27, 37);
            end else begin
                r = $urandom_range(0, 16);
                f = $urandom_range(0, 2);
            end
            run_window(r, f, 256);
        end

        // final disable leaves everything cleared
        en = 1'b0;
        model_clear();
        push_exp(cyc + 1);
        push_exp(cyc + 5);
        repeat (10) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
